alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/sequencing stage on the driving side of the ALU. Accepts one instruction
//  per valid/ready handshake, decodes R-type opcode/funct into the 4-bit ALU control,
//  reads rs/rt from the register file, and issues operands to the ALU. It waits for the
//  result, then writes it back to rd. Flags illegal instructions and counts retired ones.
// PARAMETERS
//  ALU_LAT  1  cycles from issue to valid ALU result; legal range 1..15
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  instr_valid  in   1   instruction offered
//  instr        in   32  instruction word
//  instr_ready  out  1   stage idle, can accept
//  rf_raddr1    out  5   rs address (instr[25:21])
//  rf_raddr2    out  5   rt address (instr[20:16])
//  rf_rdata1    in   32  rs data, combinational from rf_raddr1
//  rf_rdata2    in   32  rt data, combinational from rf_raddr2
//  alu_valid    out  1   one-cycle issue strobe to ALU
//  alu_control  out  4   ALU op code
//  alu_in1      out  32  operand A (rs)
//  alu_in2      out  32  operand B (rt)
//  alu_result   in   32  ALU result
//  alu_zero     in   1   ALU zero flag
//  wb_en        out  1   one-cycle register write strobe
//  wb_addr      out  5   destination (instr[15:11])
//  wb_data      out  32  write data
//  wb_zero      out  1   captured zero flag, valid with wb_en
//  illegal      out  1   one-cycle pulse on undecodable instruction
//  retired_cnt  out  32  count of wb_en pulses, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Decode: opcode==6'b000000 required; funct 100100 AND->0000, 100101 OR->0001,
//   100000 ADD->0010, 100010 SUB->0110, 101010 SLT->0111. Any other opcode/funct is illegal.
//  FSM: IDLE -> DECODE -> ISSUE -> WAIT -> WB -> IDLE; DECODE -> ERR -> IDLE.
//   IDLE:   instr_ready=1; on instr_valid the instr is captured and the FSM goes to DECODE.
//   DECODE: rf_raddr1/2 driven from captured instr; rf_rdata1/2 and control registered.
//           Illegal -> ERR, else -> ISSUE.
//   ERR:    illegal=1 for one cycle; no ALU issue, no wb; -> IDLE.
//   ISSUE:  alu_valid=1 for exactly one cycle; wait counter loaded with ALU_LAT-1; -> WAIT.
//   WAIT:   alu_in1/2 and alu_control held stable; counter decrements. At 0, alu_result and
//           alu_zero are captured; -> WB.
//   WB:     wb_en=1 for one cycle with wb_addr/wb_data/wb_zero; retired_cnt+1; -> IDLE.
//  Latency: accept on edge T, wb_en high in cycle T+3+ALU_LAT. Throughput: one instr per 4+ALU_LAT cycles.
//  rd==0: wb_en is still pulsed and retired_cnt still increments; wb_data forced to 0.
//  instr_ready is 0 in every state but IDLE; instr_valid outside IDLE is ignored.
//  Outputs outside their strobe cycle hold their last values; strobes are never held high.
//  Reset at any state: next edge -> IDLE; every output 0 except instr_ready=1.
//   The in-flight instr is dropped and produces no wb_en or illegal pulse; retired_cnt=0.
//  Reset and instr_valid in the same cycle: reset wins and the instr is not accepted.
// STRUCTURE
//  Package alu_pkg: OPC_RTYPE, FUNCT_* constants, ALU_AND/OR/ADD/SUB/SLT 4-bit codes,
//   state encoding for the FSM.
//  Sub-module alu_ctrl_decode (combinational): opcode+funct -> {control[3:0], illegal}.
//   Shared with any future decode path.
// TESTING
//  ADD: rs=1 (5), rt=2 (7), rd=3, ALU_LAT=1 -> alu_control=0010 at T+2, wb_en at T+4,
//   wb_addr=3, wb_data=12.
//  SUB equal operands: 9-9 -> wb_data=0, wb_zero=1. SLT 3<8 -> wb_data=1, wb_zero=0.
//  Illegal: instr=32'h8C000000 (opcode 100011) -> illegal pulse at T+2, no alu_valid,
//   no wb_en, instr_ready=1 at T+3.
//  Back-to-back: instr_valid held high with 3 ADDs -> accepted every 5 cycles,
//   retired_cnt=3; ALU_LAT=4 -> wb_en at T+7.
//  Reset in WAIT: rst asserted for one cycle -> no wb_en, retired_cnt=0, instr_ready=1
//   on the next edge; the following instr processes normally.
//  rd=0 AND: wb_en pulses with wb_data=0; retired_cnt preset 32'hFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue stage: R-type opcode/funct fields,
// ALU control codes and the sequencing FSM state encoding.
package alu_pkg;

   localparam logic [5:0] OPC_RTYPE  = 6'b000000;

   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_OR     = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_SLT    = 4'b0111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ERR,
      ST_ISSUE,
      ST_WAIT,
      ST_WB
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, register-file read, ALU and write-back
// signals. The issue stage connects through the slave modport.
interface alu_issue_ctrl_if;

   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        alu_valid;
   logic [3:0]  alu_control;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_zero;
   logic        illegal;
   logic [31:0] retired_cnt;

   modport slave (
      input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_result, alu_zero,
      output instr_ready, rf_raddr1, rf_raddr2, alu_valid, alu_control,
             alu_in1, alu_in2, wb_en, wb_addr, wb_data, wb_zero, illegal,
             retired_cnt
   );

   modport master (
      output instr_valid, instr, rf_rdata1, rf_rdata2, alu_result, alu_zero,
      input  instr_ready, rf_raddr1, rf_raddr2, alu_valid, alu_control,
             alu_in1, alu_in2, wb_en, wb_addr, wb_data, wb_zero, illegal,
             retired_cnt
   );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational R-type decoder: opcode + funct -> 4-bit ALU control and an
// illegal flag. Kept separate so other decode paths can reuse it.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] control_o,
   output logic       illegal_o
);

   always_comb begin
      control_o = ALU_AND;
      illegal_o = 1'b1;
      if (opcode_i == OPC_RTYPE) begin
         illegal_o = 1'b0;
         case (funct_i)
            FUNCT_AND: control_o = ALU_AND;
            FUNCT_OR:  control_o = ALU_OR;
            FUNCT_ADD: control_o = ALU_ADD;
            FUNCT_SUB: control_o = ALU_SUB;
            FUNCT_SLT: control_o = ALU_SLT;
            default:   illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage in front of the ALU: accepts an instruction, reads
// operands, issues to the ALU, waits ALU_LAT cycles and writes the result back.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1
)(
   input  logic           clk,
   input  logic           rst,
   alu_issue_ctrl_if.slave bus
);

   localparam logic [3:0] WAIT_LOAD = 4'(ALU_LAT - 1);

   state_e      state_q, state_d;
   logic [31:0] instr_q;
   logic [31:0] op_a_q;
   logic [31:0] op_b_q;
   logic [3:0]  ctrl_q;
   logic [3:0]  wait_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] wb_data_q;
   logic        wb_zero_q;
   logic [31:0] retired_q;

   logic [3:0]  dec_control;
   logic        dec_illegal;
   logic        shamt_unused;

   assign shamt_unused = ^instr_q[10:6];

   alu_ctrl_decode u_decode (
      .opcode_i  (instr_q[31:26]),
      .funct_i   (instr_q[5:0]),
      .control_o (dec_control),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.instr_valid) state_d = ST_DECODE;
         ST_DECODE: state_d = dec_illegal ? ST_ERR : ST_ISSUE;
         ST_ERR:    state_d = ST_IDLE;
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT:   if (wait_q == 4'd0) state_d = ST_WB;
         ST_WB:     state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         ctrl_q    <= '0;
         wait_q    <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_zero_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (bus.instr_valid) instr_q <= bus.instr;
            end
            ST_DECODE: begin
               // Illegal instructions leave the ALU-facing operands untouched.
               if (!dec_illegal) begin
                  op_a_q <= bus.rf_rdata1;
                  op_b_q <= bus.rf_rdata2;
                  ctrl_q <= dec_control;
               end
            end
            ST_ISSUE: begin
               wait_q <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (wait_q == 4'd0) begin
                  wb_addr_q <= instr_q[15:11];
                  wb_data_q <= (instr_q[15:11] == 5'd0) ? 32'd0 : bus.alu_result;
                  wb_zero_q <= bus.alu_zero;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            ST_WB: begin
               retired_q <= retired_q + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.instr_ready = (state_q == ST_IDLE);
   assign bus.alu_valid   = (state_q == ST_ISSUE);
   assign bus.wb_en       = (state_q == ST_WB);
   assign bus.illegal     = (state_q == ST_ERR);
   assign bus.rf_raddr1   = instr_q[25:21];
   assign bus.rf_raddr2   = instr_q[20:16];
   assign bus.alu_control = ctrl_q;
   assign bus.alu_in1     = op_a_q;
   assign bus.alu_in2     = op_b_q;
   assign bus.wb_addr     = wb_addr_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_zero     = wb_zero_q;
   assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: two instances (ALU_LAT 1 and 4) sharing a
// register-file image, with a combinational ALU model behind each.
module tb_alu_issue_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus1();
   alu_issue_ctrl_if bus4();

   alu_issue_ctrl #(.ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   alu_issue_ctrl #(.ALU_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] f);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, f};
   endfunction

   always_comb begin
      bus1.rf_rdata1  = rf[bus1.rf_raddr1];
      bus1.rf_rdata2  = rf[bus1.rf_raddr2];
      bus1.alu_result = alu_f(bus1.alu_control, bus1.alu_in1, bus1.alu_in2);
      bus1.alu_zero   = (bus1.alu_result == 32'd0);
      bus4.rf_rdata1  = rf[bus4.rf_raddr1];
      bus4.rf_rdata2  = rf[bus4.rf_raddr2];
      bus4.alu_result = alu_f(bus4.alu_control, bus4.alu_in1, bus4.alu_in2);
      bus4.alu_zero   = (bus4.alu_result == 32'd0);
   end

   // Results of the most recent run_instr on the ALU_LAT=1 instance; cycle
   // numbers count edges after the accepting edge T (0 = not seen).
   int          r_wb_cyc, r_ill_cyc, r_rdy_cyc, r_valid_cnt, r_wb_cnt;
   logic [3:0]  r_ctrl;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_addr;
   logic        r_wb_zero;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [31:0] ins);
      int to = 0;
      r_wb_cyc = 0; r_ill_cyc = 0; r_rdy_cyc = 0; r_valid_cnt = 0; r_wb_cnt = 0;
      r_ctrl = 'x; r_wb_data = 'x; r_wb_addr = 'x; r_wb_zero = 1'bx;
      while (!bus1.instr_ready && to < 50) begin cyc(); to++; end
      n_cmp++;
      if (bus1.instr_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_timeout: instr_ready=%b required 1", bus1.instr_ready);
      end
      bus1.instr = ins;
      bus1.instr_valid = 1'b1;
      cyc();
      bus1.instr_valid = 1'b0;
      for (int j = 0; j < 20; j++) begin
         if (bus1.alu_valid) begin r_valid_cnt++; r_ctrl = bus1.alu_control; end
         if (bus1.wb_en) begin
            r_wb_cnt++; r_wb_cyc = j + 1;
            r_wb_data = bus1.wb_data; r_wb_addr = bus1.wb_addr; r_wb_zero = bus1.wb_zero;
         end
         if (bus1.illegal) r_ill_cyc = j + 1;
         if (bus1.instr_ready && r_rdy_cyc == 0) r_rdy_cyc = j + 1;
         cyc();
      end
      $display("txn instr=%08h ctrl=%b wb_cyc=%0d wb_addr=%0d wb_data=%08h wb_zero=%b ill_cyc=%0d rdy_cyc=%0d retired=%0d",
               ins, r_ctrl, r_wb_cyc, r_wb_addr, r_wb_data, r_wb_zero, r_ill_cyc, r_rdy_cyc, bus1.retired_cnt);
   endtask

   task automatic check_rtype(input string nm, input logic [3:0] ctrl, input logic [4:0] addr,
                              input logic [31:0] data, input logic zero, input logic [31:0] ret);
      n_cmp++; if (r_valid_cnt !== 1) begin n_fail++; $display("FAIL %s alu_valid_pulses: got %0d required 1", nm, r_valid_cnt); end
      n_cmp++; if (r_ctrl !== ctrl) begin n_fail++; $display("FAIL %s alu_control_T+2: got %b required %b", nm, r_ctrl, ctrl); end
      n_cmp++; if (r_wb_cnt !== 1 || r_wb_cyc !== 4) begin n_fail++; $display("FAIL %s wb_en: got %0d pulses at T+%0d required 1 at T+4", nm, r_wb_cnt, r_wb_cyc); end
      n_cmp++; if (r_wb_addr !== addr) begin n_fail++; $display("FAIL %s wb_addr: got %0d required %0d", nm, r_wb_addr, addr); end
      n_cmp++; if (r_wb_data !== data) begin n_fail++; $display("FAIL %s wb_data: got %08h required %08h", nm, r_wb_data, data); end
      n_cmp++; if (r_wb_zero !== zero) begin n_fail++; $display("FAIL %s wb_zero: got %b required %b", nm, r_wb_zero, zero); end
      n_cmp++; if (r_rdy_cyc !== 5 || r_ill_cyc !== 0) begin n_fail++; $display("FAIL %s ready/illegal: rdy T+%0d ill T+%0d required T+5 and none", nm, r_rdy_cyc, r_ill_cyc); end
      n_cmp++; if (bus1.retired_cnt !== ret) begin n_fail++; $display("FAIL %s retired_cnt: got %0d required %0d", nm, bus1.retired_cnt, ret); end
      n_cmp++; if (bus1.wb_data !== data) begin n_fail++; $display("FAIL %s wb_data_hold: got %08h required %08h", nm, bus1.wb_data, data); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus1.instr_valid = 1'b1;
      bus1.instr = mk_r(1, 2, 3, 6'b100000);
      bus4.instr_valid = 1'b0;
      bus4.instr = '0;
      cyc(); cyc();
      n_cmp++; if (bus1.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset instr_ready: got %b required 1", bus1.instr_ready); end
      n_cmp++; if ({bus1.alu_valid, bus1.wb_en, bus1.illegal, bus1.wb_zero} !== 4'b0) begin n_fail++; $display("FAIL reset strobes: got %b required 0000", {bus1.alu_valid, bus1.wb_en, bus1.illegal, bus1.wb_zero}); end
      n_cmp++; if ({bus1.alu_control, bus1.alu_in1, bus1.alu_in2, bus1.wb_addr, bus1.wb_data, bus1.rf_raddr1, bus1.rf_raddr2} !== '0) begin n_fail++; $display("FAIL reset data_outputs: got nonzero required 0"); end
      n_cmp++; if (bus1.retired_cnt !== 32'd0 || bus4.retired_cnt !== 32'd0) begin n_fail++; $display("FAIL reset retired_cnt: got %0d/%0d required 0", bus1.retired_cnt, bus4.retired_cnt); end
      // Release reset with valid still high for the reset edge only: instr must not be taken.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus1.instr_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         n_cmp++;
         if (bus1.wb_en !== 1'b0 || bus1.instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_vs_valid: wb_en=%b instr_ready=%b required 0/1", bus1.wb_en, bus1.instr_ready);
         end
         cyc();
      end
      $display("txn reset done retired=%0d", bus1.retired_cnt);
   endtask

   task automatic test_add();
      run_instr(mk_r(1, 2, 3, 6'b100000));
      check_rtype("add", 4'b0010, 5'd3, 32'd12, 1'b0, 32'd1);
      n_cmp++; if (bus1.alu_in1 !== 32'd5 || bus1.alu_in2 !== 32'd7) begin n_fail++; $display("FAIL add operands: got %0d,%0d required 5,7", bus1.alu_in1, bus1.alu_in2); end
   endtask

   task automatic test_sub_zero();
      run_instr(mk_r(4, 5, 10, 6'b100010));
      check_rtype("sub_eq", 4'b0110, 5'd10, 32'd0, 1'b1, 32'd2);
   endtask

   task automatic test_slt();
      run_instr(mk_r(6, 7, 11, 6'b101010));
      check_rtype("slt", 4'b0111, 5'd11, 32'd1, 1'b0, 32'd3);
   endtask

   task automatic test_or();
      run_instr(mk_r(8, 9, 12, 6'b100101));
      check_rtype("or", 4'b0001, 5'd12, 32'h0000FFF0, 1'b0, 32'd4);
   endtask

   task automatic test_illegal();
      logic [31:0] ill_words [2];
      ill_words[0] = 32'h8C000000;
      ill_words[1] = mk_r(1, 2, 3, 6'b100111);
      for (int k = 0; k < 2; k++) begin
         run_instr(ill_words[k]);
         n_cmp++; if (r_ill_cyc !== 2) begin n_fail++; $display("FAIL illegal%0d pulse: got T+%0d required T+2", k, r_ill_cyc); end
         n_cmp++; if (r_valid_cnt !== 0 || r_wb_cnt !== 0) begin n_fail++; $display("FAIL illegal%0d side_effects: alu_valid %0d wb_en %0d required 0/0", k, r_valid_cnt, r_wb_cnt); end
         n_cmp++; if (r_rdy_cyc !== 3) begin n_fail++; $display("FAIL illegal%0d ready: got T+%0d required T+3", k, r_rdy_cyc); end
         n_cmp++; if (bus1.retired_cnt !== 32'd4 || bus1.alu_in1 !== 32'h0000F0F0) begin n_fail++; $display("FAIL illegal%0d state_kept: retired %0d alu_in1 %08h required 4 / 0000f0f0", k, bus1.retired_cnt, bus1.alu_in1); end
      end
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      int wbs = 0;
      int acc_cyc [3];
      bus1.instr = mk_r(1, 2, 13, 6'b100000);
      bus1.instr_valid = 1'b1;
      for (int j = 0; j < 40; j++) begin
         if (acc == 3) bus1.instr_valid = 1'b0;
         if (bus1.wb_en) wbs++;
         if (bus1.instr_valid && bus1.instr_ready) begin acc_cyc[acc] = j; acc++; end
         cyc();
      end
      bus1.instr_valid = 1'b0;
      $display("txn back_to_back accepted=%0d wb=%0d cycles=%0d,%0d,%0d retired=%0d", acc, wbs, acc_cyc[0], acc_cyc[1], acc_cyc[2], bus1.retired_cnt);
      n_cmp++; if (acc !== 3 || wbs !== 3) begin n_fail++; $display("FAIL b2b counts: accepted %0d wb %0d required 3/3", acc, wbs); end
      n_cmp++; if (acc == 3 && (acc_cyc[1] - acc_cyc[0] !== 5 || acc_cyc[2] - acc_cyc[1] !== 5)) begin n_fail++; $display("FAIL b2b spacing: got %0d,%0d required 5,5", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
      n_cmp++; if (bus1.retired_cnt !== 32'd7 || bus1.wb_addr !== 5'd13) begin n_fail++; $display("FAIL b2b retired: got %0d addr %0d required 7 / 13", bus1.retired_cnt, bus1.wb_addr); end
   endtask

   task automatic test_reset_in_wait();
      int seen_valid = 0;
      int wbs = 0;
      bus1.instr = mk_r(1, 2, 14, 6'b100000);
      bus1.instr_valid = 1'b1;
      cyc();
      bus1.instr_valid = 1'b0;
      cyc();
      if (bus1.alu_valid) seen_valid = 1;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_cmp++; if (seen_valid !== 1) begin n_fail++; $display("FAIL rst_wait issue_before: got %0d required 1", seen_valid); end
      n_cmp++; if (bus1.instr_ready !== 1'b1 || bus1.wb_en !== 1'b0 || bus1.retired_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_wait after_edge: ready %b wb_en %b retired %0d required 1/0/0", bus1.instr_ready, bus1.wb_en, bus1.retired_cnt); end
      for (int j = 0; j < 6; j++) begin
         if (bus1.wb_en) wbs++;
         cyc();
      end
      n_cmp++; if (wbs !== 0 || bus1.wb_addr !== 5'd0) begin n_fail++; $display("FAIL rst_wait dropped: wb pulses %0d wb_addr %0d required 0/0", wbs, bus1.wb_addr); end
      $display("txn reset_in_wait retired=%0d", bus1.retired_cnt);
      run_instr(mk_r(1, 2, 3, 6'b100000));
      check_rtype("after_rst", 4'b0010, 5'd3, 32'd12, 1'b0, 32'd1);
   endtask

   task automatic test_lat4();
      int wb_cyc = 0;
      int rdy_cyc = 0;
      logic [31:0] wdata = 'x;
      bus4.instr = mk_r(1, 2, 3, 6'b100000);
      bus4.instr_valid = 1'b1;
      cyc();
      bus4.instr_valid = 1'b0;
      for (int j = 0; j < 20; j++) begin
         if (bus4.wb_en) begin wb_cyc = j + 1; wdata = bus4.wb_data; end
         if (bus4.instr_ready && rdy_cyc == 0) rdy_cyc = j + 1;
         cyc();
      end
      $display("txn lat4 wb_cyc=%0d wb_data=%08h rdy_cyc=%0d retired=%0d", wb_cyc, wdata, rdy_cyc, bus4.retired_cnt);
      n_cmp++; if (wb_cyc !== 7) begin n_fail++; $display("FAIL lat4 wb_timing: got T+%0d required T+7", wb_cyc); end
      n_cmp++; if (wdata !== 32'd12 || bus4.retired_cnt !== 32'd1) begin n_fail++; $display("FAIL lat4 result: data %08h retired %0d required 0000000c / 1", wdata, bus4.retired_cnt); end
      n_cmp++; if (rdy_cyc !== 8) begin n_fail++; $display("FAIL lat4 ready: got T+%0d required T+8", rdy_cyc); end
   endtask

   task automatic test_rd0_wrap();
      force dut1.retired_q = 32'hFFFF_FFFF;
      cyc();
      release dut1.retired_q;
      cyc();
      n_cmp++; if (bus1.retired_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap preset: got %08h required ffffffff", bus1.retired_cnt); end
      run_instr(mk_r(8, 9, 0, 6'b100100));
      check_rtype("and_rd0", 4'b0000, 5'd0, 32'd0, 1'b0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rf[1] = 32'd5;  rf[2] = 32'd7;
      rf[4] = 32'd9;  rf[5] = 32'd9;
      rf[6] = 32'd3;  rf[7] = 32'd8;
      rf[8] = 32'h0000F0F0; rf[9] = 32'h0000FF00;
      test_reset();
      test_add();
      test_sub_zero();
      test_slt();
      test_or();
      test_illegal();
      test_back_to_back();
      test_reset_in_wait();
      test_lat4();
      test_rd0_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
